// File: rtl/btn_event_gen_if.sv
// Button event bundle: enable and debounced levels in, per-button event pulses out.
interface btn_event_gen_if #(
  parameter int N = 4
);
  logic         en;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] fire_pulse;
  logic [N-1:0] held;

  modport master (
    output en, btn_level,
    input  press_pulse, release_pulse, fire_pulse, held
  );

  modport slave (
    input  en, btn_level,
    output press_pulse, release_pulse, fire_pulse, held
  );
endinterface

// File: rtl/btn_event_gen.sv
// Per-button press/release/auto-repeat event generator driven by a shared ms prescaler.
module btn_event_gen #(
  parameter int            N         = 4,
  parameter int            TICK_DIV  = 100000,
  parameter int            HOLD_MS   = 400,
  parameter int            RATE_MS   = 100,
  parameter logic [N-1:0]  REPEAT_EN = {N{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  btn_event_gen_if.slave bus
);
  localparam int PW     = $clog2(TICK_DIV);
  localparam int MS_MAX = (HOLD_MS > RATE_MS) ? HOLD_MS : RATE_MS;
  localparam int MW     = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] HOLD_LAST  = MW'(HOLD_MS - 1);
  localparam logic [MW-1:0] HOLD_SAT   = MW'(HOLD_MS);
  localparam logic [MW-1:0] RATE_LAST  = MW'(RATE_MS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [N-1:0]  btn_q, btn_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [N-1:0]  rise, fall;

  state_e        state_q [N];
  state_e        state_d [N];
  logic [MW-1:0] ms_q [N];
  logic [MW-1:0] ms_d [N];

  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  release_q, release_d;
  logic [N-1:0]  fire_q, fire_d;
  logic [N-1:0]  held_q, held_d;

  // Stage 0: edge detect on the debounced levels and the shared ms tick
  assign rise    = btn_q & ~btn_prev_q;
  assign fall    = ~btn_q & btn_prev_q;
  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Stage 1: per-button FSM; a fall takes priority over a same-cycle tick
  always_comb begin
    press_d   = '0;
    release_d = '0;
    fire_d    = '0;
    held_d    = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      ms_d[i]    = ms_q[i];
      if (!bus.en) begin
        state_d[i] = IDLE;
        ms_d[i]    = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              press_d[i] = 1'b1;
              fire_d[i]  = 1'b1;
              ms_d[i]    = '0;
              state_d[i] = HOLD;
            end
          end
          HOLD: begin
            if (fall[i]) begin
              release_d[i] = 1'b1;
              state_d[i]   = IDLE;
            end else if (tick && ms_q[i] != HOLD_SAT) begin
              if (ms_q[i] == HOLD_LAST && REPEAT_EN[i]) begin
                fire_d[i]  = 1'b1;
                ms_d[i]    = '0;
                state_d[i] = REPEAT;
              end else begin
                ms_d[i] = ms_q[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (fall[i]) begin
              release_d[i] = 1'b1;
              state_d[i]   = IDLE;
            end else if (tick) begin
              if (ms_q[i] == RATE_LAST) begin
                fire_d[i] = 1'b1;
                ms_d[i]   = '0;
              end else begin
                ms_d[i] = ms_q[i] + 1'b1;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            ms_d[i]    = '0;
          end
        endcase
      end
      held_d[i] = (state_d[i] != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= '0;
      btn_prev_q <= '0;
      presc_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      fire_q     <= '0;
      held_q     <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        ms_q[i]    <= '0;
      end
    end else begin
      btn_q      <= bus.btn_level;
      btn_prev_q <= btn_q;
      presc_q    <= presc_d;
      press_q    <= press_d;
      release_q  <= release_d;
      fire_q     <= fire_d;
      held_q     <= held_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        ms_q[i]    <= ms_d[i];
      end
    end
  end

  // Stage 2: registered event outputs
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.fire_pulse    = fire_q;
  assign bus.held          = held_q;
endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: two instances (full and partial repeat mask) against a tick-count reference model.
module tb_btn_event_gen;
  localparam int TICK = 4;
  localparam int HOLD = 3;
  localparam int RATE = 2;
  localparam logic [3:0] MASK_A = 4'b1111;
  localparam logic [3:0] MASK_B = 4'b1110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_r = 1'b1;
  logic [3:0] lvl_r = 4'b0000;

  always #5 clk = ~clk;

  btn_event_gen_if #(.N(4)) if_a ();
  btn_event_gen_if #(.N(4)) if_b ();

  assign if_a.en        = en_r;
  assign if_a.btn_level = lvl_r;
  assign if_b.en        = en_r;
  assign if_b.btn_level = lvl_r;

  btn_event_gen #(.N(4), .TICK_DIV(TICK), .HOLD_MS(HOLD), .RATE_MS(RATE), .REPEAT_EN(MASK_A))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  btn_event_gen #(.N(4), .TICK_DIV(TICK), .HOLD_MS(HOLD), .RATE_MS(RATE), .REPEAT_EN(MASK_B))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, want %b", tag, $time, obs, exp);
    end
  endtask

  // Reference: a button fires when the number of ms ticks seen since its last
  // press/fire equals the hold or repeat interval; levels are seen two edges late.
  logic [3:0] mq, mp;
  int         m_edges, m_ticks;
  bit         act  [2][4];
  bit         rep  [2][4];
  int         base [2][4];
  logic [3:0] e_press [2];
  logic [3:0] e_rel   [2];
  logic [3:0] e_fire  [2];
  logic [3:0] e_held  [2];

  function automatic logic [3:0] mask_of(input int d);
    return (d == 0) ? MASK_A : MASK_B;
  endfunction

  task automatic model_reset();
    mq = '0; mp = '0; m_edges = 0; m_ticks = 0;
    for (int d = 0; d < 2; d++) begin
      e_press[d] = '0; e_rel[d] = '0; e_fire[d] = '0; e_held[d] = '0;
      for (int i = 0; i < 4; i++) begin
        act[d][i] = 0; rep[d][i] = 0; base[d][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0] rise, fall, m;
    bit tick;
    int need;
    rise = mq & ~mp;
    fall = ~mq & mp;
    tick = ((m_edges % TICK) == TICK - 1);
    if (tick) m_ticks++;
    m_edges++;
    for (int d = 0; d < 2; d++) begin
      m = mask_of(d);
      e_press[d] = '0; e_rel[d] = '0; e_fire[d] = '0; e_held[d] = '0;
      for (int i = 0; i < 4; i++) begin
        need = rep[d][i] ? RATE : HOLD;
        if (!en_r) begin
          act[d][i] = 0;
          rep[d][i] = 0;
        end else if (!act[d][i]) begin
          if (rise[i]) begin
            e_press[d][i] = 1'b1;
            e_fire[d][i]  = 1'b1;
            act[d][i]  = 1;
            rep[d][i]  = 0;
            base[d][i] = m_ticks;
          end
        end else if (fall[i]) begin
          e_rel[d][i] = 1'b1;
          act[d][i]   = 0;
          rep[d][i]   = 0;
        end else if (tick && m[i] && (m_ticks - base[d][i]) == need) begin
          e_fire[d][i] = 1'b1;
          base[d][i]   = m_ticks;
          rep[d][i]    = 1;
        end
        e_held[d][i] = act[d][i];
      end
    end
    mp = mq;
    mq = lvl_r;
  endtask

  task automatic compare();
    check_val("a_press",   if_a.press_pulse,   e_press[0]);
    check_val("a_release", if_a.release_pulse, e_rel[0]);
    check_val("a_fire",    if_a.fire_pulse,    e_fire[0]);
    check_val("a_held",    if_a.held,          e_held[0]);
    check_val("b_press",   if_b.press_pulse,   e_press[1]);
    check_val("b_release", if_b.release_pulse, e_rel[1]);
    check_val("b_fire",    if_b.fire_pulse,    e_fire[1]);
    check_val("b_held",    if_b.held,          e_held[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    rst = 1'b0;

    steps(20);

    // Long hold on button 0: repeats on instance A, single fire on instance B
    lvl_r[0] = 1'b1;
    steps(40);
    lvl_r[0] = 1'b0;
    steps(10);

    // Sweep release timing of button 1 across a full repeat period
    for (int k = 0; k < 2 * RATE * TICK; k++) begin
      while ((m_edges % TICK) != 0) step();
      lvl_r[1] = 1'b1;
      steps(20 + k);
      lvl_r[1] = 1'b0;
      steps(6);
    end

    // Button 2 held across an enable drop
    lvl_r[2] = 1'b1;
    steps(15);
    en_r = 1'b0;
    steps(5);
    en_r = 1'b1;
    steps(10);
    lvl_r[2] = 1'b0;
    steps(5);
    lvl_r[2] = 1'b1;
    steps(10);
    lvl_r[2] = 1'b0;
    steps(5);

    // Single-cycle level pulse
    lvl_r[3] = 1'b1;
    steps(1);
    lvl_r[3] = 1'b0;
    steps(6);

    // Simultaneous press on 0 and 3, then asynchronous reset mid-repeat
    lvl_r = 4'b1001;
    steps(25);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    rst = 1'b0;
    steps(15);
    lvl_r = 4'b0000;
    steps(6);

    // Randomized levels and enable
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(11) == 0) lvl_r[i] = ~lvl_r[i];
      if (en_r && $urandom_range(49) == 0) en_r = 1'b0;
      else if (!en_r && $urandom_range(3) == 0) en_r = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
